// File: rtl/sap_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : sap_run_controller
// Purpose  : SAP-1 run/load sequencer: streams a program image into RAM, then
//            gates the CPU clock enable for continuous run or single-step.
// Revision : 1.0 - initial release
// ============================================================================
module sap_run_controller #(
    parameter  int RAM_DEPTH     = 16,
    parameter  int RAM_WIDTH     = 8,
    localparam int ADDRESS_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                     mclk,
    input  logic                     i_reset,
    input  logic                     i_tick,
    input  logic                     i_load_start,
    input  logic                     i_run,
    input  logic                     i_step,
    input  logic                     i_stop,
    input  logic                     i_load_valid,
    input  logic [RAM_WIDTH-1:0]     i_load_data,
    output logic                     o_load_ready,
    input  logic                     i_cpu_halt,
    input  logic                     i_cpu_rami,
    input  logic [ADDRESS_WIDTH-1:0] i_cpu_address,
    input  logic [RAM_WIDTH-1:0]     i_cpu_data,
    output logic                     o_ram_en,
    output logic                     o_ram_we,
    output logic [ADDRESS_WIDTH-1:0] o_ram_address,
    output logic [RAM_WIDTH-1:0]     o_ram_data,
    output logic                     o_cpu_mclk_en,
    output logic                     o_cpu_reset,
    output logic [2:0]               o_state,
    output logic                     o_load_done,
    output logic [RAM_WIDTH-1:0]     o_checksum
);

    localparam logic [ADDRESS_WIDTH-1:0] c_last_addr = ADDRESS_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       r_reset_pending;
    logic                       w_set_pending;
    logic                       w_clr_pending;
    logic                       w_enter_load;
    logic                       w_accept;
    logic                       w_last;
    logic                       w_loader_sel;
    logic [ADDRESS_WIDTH-1:0]   r_count;
    logic [RAM_WIDTH-1:0]       r_checksum;
    logic                       r_load_done;
    logic                       r_ld_we;
    logic [ADDRESS_WIDTH-1:0]   r_ld_addr;
    logic [RAM_WIDTH-1:0]       r_ld_data;

    assign o_load_ready = (r_state == ST_LOAD);
    assign w_accept     = i_load_valid & o_load_ready;
    assign w_last       = (r_count == c_last_addr);
    assign w_enter_load = (w_state_next == ST_LOAD) && (r_state != ST_LOAD);

    always_comb begin
        w_state_next  = r_state;
        w_set_pending = 1'b0;
        w_clr_pending = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_load_start) begin
                    w_state_next = ST_LOAD;
                end else if (i_run) begin
                    w_state_next  = ST_RUN;
                    w_clr_pending = 1'b1;
                end else if (i_step) begin
                    w_state_next  = ST_STEP;
                    w_clr_pending = 1'b1;
                end
            end
            ST_LOAD: begin
                if (w_accept && w_last) begin
                    w_state_next  = ST_IDLE;
                    w_set_pending = 1'b1;
                end
            end
            ST_RUN: begin
                // A stop in the same cycle as a halting tick pauses rather than halts
                if (i_stop) begin
                    w_state_next = ST_IDLE;
                end else if (i_tick && i_cpu_halt) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_STEP: begin
                if (i_tick) begin
                    w_state_next = i_cpu_halt ? ST_HALTED : ST_IDLE;
                end else if (i_stop) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (i_load_start) begin
                    w_state_next = ST_LOAD;
                end else if (i_stop) begin
                    w_state_next  = ST_IDLE;
                    w_set_pending = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_reset_pending <= 1'b1;
            r_count         <= '0;
            r_checksum      <= '0;
            r_load_done     <= 1'b0;
            r_ld_we         <= 1'b0;
            r_ld_addr       <= '0;
            r_ld_data       <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_set_pending) begin
                r_reset_pending <= 1'b1;
            end else if (w_clr_pending) begin
                r_reset_pending <= 1'b0;
            end
            r_ld_we <= w_accept;
            if (w_enter_load) begin
                r_count     <= '0;
                r_checksum  <= '0;
                r_load_done <= 1'b0;
            end else if (w_accept) begin
                r_ld_addr  <= r_count;
                r_ld_data  <= i_load_data;
                r_checksum <= r_checksum + i_load_data;
                r_count    <= r_count + 1'b1;
                if (w_last) begin
                    r_load_done <= 1'b1;
                end
            end
        end
    end

    assign o_cpu_mclk_en = ((r_state == ST_RUN) || (r_state == ST_STEP)) && i_tick;
    assign o_cpu_reset   = (r_state == ST_LOAD) || r_reset_pending;
    assign o_state       = r_state;
    assign o_load_done   = r_load_done;
    assign o_checksum    = r_checksum;

    // The loader keeps the port one cycle past LOAD so the final byte still lands
    assign w_loader_sel  = (r_state == ST_LOAD) || r_ld_we;
    assign o_ram_en      = w_loader_sel ? r_ld_we   : o_cpu_mclk_en;
    assign o_ram_we      = w_loader_sel ? r_ld_we   : i_cpu_rami;
    assign o_ram_address = w_loader_sel ? r_ld_addr : i_cpu_address;
    assign o_ram_data    = w_loader_sel ? r_ld_data : i_cpu_data;

endmodule
`default_nettype wire

// File: tb/tb_sap_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sap_run_controller
// Purpose  : Self-checking bench for sap_run_controller: directed load/run/step
//            sequences, a vector table for the RAM mux, and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sap_run_controller;

    logic       mclk = 1'b0;
    logic       i_reset, i_tick, i_load_start, i_run, i_step, i_stop;
    logic       i_load_valid;
    logic [7:0] i_load_data;
    logic       o_load_ready;
    logic       i_cpu_halt, i_cpu_rami;
    logic [3:0] i_cpu_address;
    logic [7:0] i_cpu_data;
    logic       o_ram_en, o_ram_we;
    logic [3:0] o_ram_address;
    logic [7:0] o_ram_data;
    logic       o_cpu_mclk_en, o_cpu_reset;
    logic [2:0] o_state;
    logic       o_load_done;
    logic [7:0] o_checksum;

    always #5 mclk = ~mclk;

    sap_run_controller #(.RAM_DEPTH(16), .RAM_WIDTH(8)) dut (
        .mclk(mclk), .i_reset(i_reset), .i_tick(i_tick),
        .i_load_start(i_load_start), .i_run(i_run), .i_step(i_step), .i_stop(i_stop),
        .i_load_valid(i_load_valid), .i_load_data(i_load_data), .o_load_ready(o_load_ready),
        .i_cpu_halt(i_cpu_halt), .i_cpu_rami(i_cpu_rami),
        .i_cpu_address(i_cpu_address), .i_cpu_data(i_cpu_data),
        .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_address(o_ram_address),
        .o_ram_data(o_ram_data), .o_cpu_mclk_en(o_cpu_mclk_en), .o_cpu_reset(o_cpu_reset),
        .o_state(o_state), .o_load_done(o_load_done), .o_checksum(o_checksum)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode name, accumulated image, pending loader write
    int         m_state;
    bit         m_pend;
    int         m_nbytes;
    logic [7:0] m_csum;
    bit         m_done;
    bit         m_wr;
    logic [3:0] m_wa;
    logic [7:0] m_wd;

    logic [7:0] img [16];
    logic [7:0] tb_ram [16];
    int wr_count, en_count, ready_count;

    typedef struct {
        int         cmd;   // 0 none, 1 run, 2 stop
        logic       tick;
        logic       rami;
        logic [3:0] addr;
        logic [7:0] data;
        logic       exp_state_run;
        logic       exp_mclk_en;
        logic       exp_ram_en;
        logic       exp_ram_we;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pend = 1; m_nbytes = 0; m_csum = 0; m_done = 0; m_wr = 0;
    endtask

    task automatic model_begin_load();
        m_state = 1; m_nbytes = 0; m_csum = 0; m_done = 0;
    endtask

    task automatic model_step();
        bit acc;
        if (i_reset) begin
            model_reset();
            return;
        end
        acc  = (m_state == 1) && i_load_valid;
        m_wr = acc;
        if (acc) begin
            m_wa     = 4'(m_nbytes);
            m_wd     = i_load_data;
            m_csum   = m_csum + i_load_data;
            m_nbytes = m_nbytes + 1;
        end
        case (m_state)
            0: if (i_load_start) model_begin_load();
               else if (i_run) begin m_state = 2; m_pend = 0; end
               else if (i_step) begin m_state = 3; m_pend = 0; end
            1: if (acc && m_nbytes == 16) begin m_state = 0; m_done = 1; m_pend = 1; end
            2: if (i_stop) m_state = 0;
               else if (i_tick && i_cpu_halt) m_state = 4;
            3: if (i_tick) m_state = i_cpu_halt ? 4 : 0;
               else if (i_stop) m_state = 0;
            4: if (i_load_start) model_begin_load();
               else if (i_stop) begin m_state = 0; m_pend = 1; end
            default: m_state = 0;
        endcase
    endtask

    // One clock: compare every output against the model at the falling edge,
    // then advance the model on the rising edge.
    task automatic cyc();
        bit         loader, e_mclk, e_en, e_we, ok;
        logic [3:0] e_a;
        logic [7:0] e_d;
        @(negedge mclk);
        e_mclk = ((m_state == 2) || (m_state == 3)) && i_tick;
        loader = (m_state == 1) || m_wr;
        e_en   = loader ? m_wr : e_mclk;
        e_we   = loader ? m_wr : i_cpu_rami;
        e_a    = loader ? m_wa : i_cpu_address;
        e_d    = loader ? m_wd : i_cpu_data;
        ok = (o_state === 3'(m_state)) && (o_load_ready === (m_state == 1)) &&
             (o_cpu_mclk_en === e_mclk) && (o_cpu_reset === ((m_state == 1) || m_pend)) &&
             (o_ram_en === e_en) && (o_ram_we === e_we) &&
             (o_checksum === m_csum) && (o_load_done === m_done);
        if (e_we || !loader) ok = ok && (o_ram_address === e_a) && (o_ram_data === e_d);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL model_cycle t=%0t state=%0d/%0d mclk_en=%b/%b cpu_reset=%b/%b ram_en=%b/%b ram_we=%b/%b addr=%h/%h data=%h/%h csum=%h/%h done=%b/%b (actual/required)",
                     $time, o_state, m_state, o_cpu_mclk_en, e_mclk, o_cpu_reset, (m_state == 1) || m_pend,
                     o_ram_en, e_en, o_ram_we, e_we, o_ram_address, e_a, o_ram_data, e_d,
                     o_checksum, m_csum, o_load_done, m_done);
        end
        if (o_ram_we && o_ram_en) begin
            tb_ram[o_ram_address] = o_ram_data;
            wr_count++;
        end
        if (o_cpu_mclk_en) en_count++;
        if (o_load_ready) ready_count++;
        @(posedge mclk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        i_reset = 0; i_tick = 0; i_load_start = 0; i_run = 0; i_step = 0; i_stop = 0;
        i_load_valid = 0; i_load_data = 0; i_cpu_halt = 0; i_cpu_rami = 0;
        i_cpu_address = 0; i_cpu_data = 0;
    endtask

    task automatic load_image(input bit toggle);
        int idx = 0;
        i_load_start = 1; cyc(); i_load_start = 0;
        wr_count = 0; ready_count = 0;
        for (int k = 0; k < 16; k++) tb_ram[k] = 8'hxx;
        for (int c = 0; c < 80 && idx < 16; c++) begin
            i_load_valid = toggle ? (c % 2 == 1) : 1'b1;
            i_load_data  = img[idx];
            cyc();
            if (i_load_valid) idx++;
        end
        i_load_valid = 0;
        cyc();
        chk("load_write_count", wr_count, 16);
        for (int k = 0; k < 16; k++) chk($sformatf("ram_word_%0d", k), tb_ram[k], img[k]);
        chk("load_state_idle", o_state, 0);
        chk("load_done", o_load_done, 1);
        chk("load_cpu_reset", o_cpu_reset, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        vecs[0] = '{0, 1'b1, 1'b1, 4'h3, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1, 1'b1, 1'b0, 4'h7, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{0, 1'b1, 1'b1, 4'hC, 8'h81, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{0, 1'b0, 1'b1, 4'h5, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{2, 1'b1, 1'b0, 4'hF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{0, 1'b1, 1'b0, 4'h1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};

        clear_inputs();
        i_reset = 1;
        repeat (2) @(posedge mclk);
        #1;
        model_reset();
        cyc();
        i_reset = 0;

        chk("reset_state", o_state, 0);
        chk("reset_cpu_reset", o_cpu_reset, 1);
        chk("reset_mclk_en", o_cpu_mclk_en, 0);
        chk("reset_load_ready", o_load_ready, 0);
        chk("reset_ram_we", o_ram_we, 0);
        chk("reset_checksum", o_checksum, 0);
        chk("reset_load_done", o_load_done, 0);

        // Full-speed image 0x00..0x0F
        for (int k = 0; k < 16; k++) img[k] = 8'(k);
        load_image(0);
        chk("ready_cycles", ready_count, 16);
        chk("checksum_0_15", o_checksum, 8'h78);

        // Half-rate image, same contents
        load_image(1);
        chk("checksum_toggle", o_checksum, 8'h78);

        // Checksum wrap
        for (int k = 0; k < 16; k++) img[k] = 8'hFF;
        load_image(0);
        chk("checksum_wrap", o_checksum, 8'hF0);

        // Run with a tick every fourth cycle, halt on the fifth tick
        i_run = 1; cyc(); i_run = 0;
        chk("run_entry_cpu_reset", o_cpu_reset, 0);
        en_count = 0;
        for (int c = 0; c < 20; c++) begin
            i_tick     = (c % 4 == 3);
            i_cpu_halt = (c == 19);
            cyc();
        end
        i_cpu_halt = 0;
        chk("run_enable_count", en_count, 5);
        chk("halted_state", o_state, 4);
        i_tick = 1;
        repeat (8) cyc();
        i_tick = 0;
        chk("halted_no_enables", en_count, 5);

        i_stop = 1; cyc(); i_stop = 0;
        chk("halt_stop_idle", o_state, 0);
        chk("halt_stop_cpu_reset", o_cpu_reset, 1);

        // Three single steps
        for (int k = 0; k < 3; k++) begin
            e0 = en_count;
            i_step = 1; cyc(); i_step = 0;
            for (int c = 0; c < 6; c++) begin
                i_tick = (c == 2 || c == 4);
                cyc();
            end
            i_tick = 0;
            chk($sformatf("step_%0d_pulses", k), en_count - e0, 1);
            chk($sformatf("step_%0d_state", k), o_state, 0);
        end

        // Step cancelled by stop before any tick
        e0 = en_count;
        i_step = 1; cyc(); i_step = 0;
        i_stop = 1; cyc(); i_stop = 0;
        for (int c = 0; c < 4; c++) begin
            i_tick = 1; cyc();
        end
        i_tick = 0;
        chk("step_stop_pulses", en_count - e0, 0);
        chk("step_stop_state", o_state, 0);

        // Stop and halting tick in the same cycle: stop wins, tick still passes
        i_run = 1; cyc(); i_run = 0;
        cyc(); cyc();
        e0 = en_count;
        i_tick = 1; i_stop = 1; i_cpu_halt = 1;
        cyc();
        i_tick = 0; i_stop = 0; i_cpu_halt = 0;
        chk("stop_halt_pulses", en_count - e0, 1);
        chk("stop_halt_state", o_state, 0);
        chk("stop_halt_cpu_reset", o_cpu_reset, 0);
        i_run = 1; cyc(); i_run = 0;
        chk("resume_state", o_state, 2);
        i_stop = 1; cyc(); i_stop = 0;

        // RAM mux vector table from IDLE
        foreach (vecs[r]) begin
            i_run         = (vecs[r].cmd == 1);
            i_stop        = (vecs[r].cmd == 2);
            i_tick        = vecs[r].tick;
            i_cpu_rami    = vecs[r].rami;
            i_cpu_address = vecs[r].addr;
            i_cpu_data    = vecs[r].data;
            #3;
            chk($sformatf("vec%0d_state", r), o_state, vecs[r].exp_state_run ? 3'd2 : 3'd0);
            chk($sformatf("vec%0d_mclk_en", r), o_cpu_mclk_en, vecs[r].exp_mclk_en);
            chk($sformatf("vec%0d_ram_en", r), o_ram_en, vecs[r].exp_ram_en);
            chk($sformatf("vec%0d_ram_we", r), o_ram_we, vecs[r].exp_ram_we);
            chk($sformatf("vec%0d_addr", r), o_ram_address, vecs[r].addr);
            chk($sformatf("vec%0d_data", r), o_ram_data, vecs[r].data);
            cyc();
        end
        clear_inputs();

        // Reset arriving with the sixth load byte
        i_load_start = 1; cyc(); i_load_start = 0;
        for (int k = 0; k < 5; k++) begin
            i_load_valid = 1; i_load_data = 8'(8'h21 + k); cyc();
        end
        i_reset = 1; i_load_data = 8'h99; cyc();
        i_reset = 0; i_load_valid = 0;
        chk("abort_state", o_state, 0);
        chk("abort_load_done", o_load_done, 0);
        chk("abort_checksum", o_checksum, 0);
        chk("abort_ram_we", o_ram_we, 0);
        cyc();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            i_reset       = ($urandom_range(0, 299) == 0);
            i_tick        = ($urandom_range(0, 2) == 0);
            i_load_start  = ($urandom_range(0, 39) == 0);
            i_run         = ($urandom_range(0, 15) == 0);
            i_step        = ($urandom_range(0, 15) == 0);
            i_stop        = ($urandom_range(0, 19) == 0);
            i_load_valid  = $urandom_range(0, 1);
            i_load_data   = 8'($urandom);
            i_cpu_halt    = ($urandom_range(0, 7) == 0);
            i_cpu_rami    = $urandom_range(0, 1);
            i_cpu_address = 4'($urandom);
            i_cpu_data    = 8'($urandom);
            cyc();
        end
        clear_inputs();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sap_run_controller.md
# sap_run_controller

Run/load sequencer for the SAP-1 core. Sits between the free-running clock-enable generator and the CPU datapath. It owns the RAM write port while a program image is streamed in, then gates the CPU clock enable for continuous run or single-step. It stops the CPU when the decoder raises halt.

## Interface
- RAM_DEPTH, 16, RAM words; address width is clog2(RAM_DEPTH) (local, not overridable)
- RAM_WIDTH, 8, RAM word / load byte width
- mclk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_tick  in  1  base clock-enable pulse from the clock-enable generator
- i_load_start  in  1  command pulse: begin program load
- i_run / i_step / i_stop  in  1 each  command pulses
- i_load_valid  in  1  load byte valid
- i_load_data  in  RAM_WIDTH  load byte
- o_load_ready  out  1  loader accepts a byte
- i_cpu_halt  in  1  halt from instruction decoder (combinational)
- i_cpu_rami  in  1  CPU RAM write strobe
- i_cpu_address  in  ADDRESS_WIDTH  CPU memory address register
- i_cpu_data  in  RAM_WIDTH  CPU bus data
- o_ram_en  out  1  RAM clock enable
- o_ram_we  out  1  RAM load enable
- o_ram_address  out  ADDRESS_WIDTH  RAM address
- o_ram_data  out  RAM_WIDTH  RAM write data
- o_cpu_mclk_en  out  1  gated clock enable to all CPU registers/counters
- o_cpu_reset  out  1  restart request to program counter / instruction counter
- o_state  out  3  IDLE=0, LOAD=1, RUN=2, STEP=3, HALTED=4
- o_load_done  out  1  a complete image has been loaded since the last reset or load start
- o_checksum  out  RAM_WIDTH  sum of loaded bytes mod 2^RAM_WIDTH

## Operation
- One clock (mclk). Reset is synchronous and active-high (i_reset).
- Reset values:
  - State IDLE.
  - Load counter 0, checksum 0, o_load_done 0.
  - Loader write register cleared: o_ram_we 0.
  - reset_pending 1, so o_cpu_reset 1.
  - o_cpu_mclk_en 0, o_load_ready 0.
- reset_pending flag:
  - Set by reset and by load completion.
  - Set by i_stop in HALTED.
  - Cleared on entry to RUN or STEP.
- o_cpu_reset = (state==LOAD) | reset_pending.
- IDLE transitions, priority i_load_start > i_run > i_step:
  - i_load_start -> LOAD.
  - i_run -> RUN.
  - i_step -> STEP.
  - i_stop is ignored.
- LOAD:
  - Entry clears the counter and checksum, and sets o_load_done to 0.
  - o_load_ready = 1.
  - Each accepted byte (valid & ready) registers address = counter, data = byte, and we = 1 for the next cycle.
  - Each accepted byte adds to the checksum and increments the counter.
  - Acceptance of byte RAM_DEPTH-1 -> IDLE, o_load_done 1, reset_pending 1.
  - i_run, i_step, i_stop, i_load_start are ignored.
  - i_cpu_* inputs are ignored.
- RAM port mux:
  - Loader selected while state==LOAD or the registered loader we is 1. Then o_ram_en = o_ram_we = registered we, and address/data come from the loader registers.
  - Otherwise the CPU is selected. o_ram_en = o_cpu_mclk_en, o_ram_we = i_cpu_rami, and address/data pass through combinationally.
- RUN:
  - o_cpu_mclk_en = i_tick.
  - i_stop -> IDLE (pause; resume continues without restart).
  - i_tick & i_cpu_halt & !i_stop -> HALTED.
- STEP:
  - o_cpu_mclk_en = i_tick.
  - First cycle with i_tick -> IDLE, or -> HALTED if i_cpu_halt in that cycle.
  - i_stop before any tick -> IDLE with no tick passed.
- HALTED:
  - o_cpu_mclk_en 0.
  - i_load_start -> LOAD.
  - i_stop -> IDLE with reset_pending set.
  - i_run / i_step are ignored.
- IDLE: o_cpu_mclk_en 0.

## Timing
- o_cpu_mclk_en is combinational from the registered state and i_tick. Zero latency, no extra pulses, no dropped ticks while in RUN.
- Command pulses are sampled on the mclk edge. The state changes the next cycle, and the tick in the command cycle is governed by the old state.
- Load:
  - Throughput is 1 byte/cycle.
  - The RAM write occurs 1 cycle after acceptance.
  - The final write occurs in the first IDLE cycle.
  - A full image takes RAM_DEPTH accepting cycles + 1.
- Load counter wrap is impossible: LOAD exits on the last address.
- Checksum wraps modulo 2^RAM_WIDTH.
- Reset mid-load:
  - Aborts the load and the pending write is dropped.
  - o_load_done 0; the RAM contents are partially written and undefined.
- Simultaneous i_stop and halt tick in RUN: stop wins (-> IDLE). The tick in that cycle still reaches the CPU.

## Test plan
- Reset, then stream 0x00..0x0F with valid held 1:
  - o_load_ready high 16 cycles.
  - o_ram_we pulses at addresses 0..15 one cycle behind each byte.
  - o_checksum 0x78, o_load_done 1, state IDLE, o_cpu_reset 1.
- Load with valid toggling every other cycle: same RAM contents/checksum, no writes on idle cycles. Stream 16 × 0xFF: checksum 0xF0 (wrap).
- After load, i_run with i_tick every 4 cycles:
  - o_cpu_mclk_en mirrors i_tick exactly.
  - o_cpu_reset drops on RUN entry.
  - Assert i_cpu_halt at a tick -> HALTED, no further enables.
- i_step three times from IDLE: exactly one enable pulse each, state returns to IDLE. i_stop in STEP before a tick gives zero pulses.
- In RUN, assert i_stop and halt in the same tick cycle: state IDLE, one enable passed, reset_pending 0; then i_run resumes.
- Assert i_reset after 5 accepted load bytes: state IDLE, o_load_done 0, checksum 0, no o_ram_we the following cycle.
